// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM read port between fetch (F) and data loads (D).
// F has priority; a starvation counter forces a D grant after STARVE_LIMIT lost conflicts.
module rom_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     f_req,
  input  logic [ADDRESS_WIDTH-1:0] f_addr,
  input  logic                     f_flush,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [DATA_WIDTH-1:0]    f_rdata,
  output logic                     f_err,
  input  logic                     d_req,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     d_err,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0]          r_starve_cnt;
  logic [CntW-1:0]          w_starve_nxt;
  logic                     w_starved;
  logic                     w_f_gnt;
  logic                     w_d_gnt;
  logic                     w_f_mis;
  logic                     w_d_mis;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;

  logic                     r_f_valid;
  logic                     r_d_valid;
  logic                     r_f_err;
  logic                     r_d_err;
  logic [DATA_WIDTH-1:0]    r_f_rdata;
  logic [DATA_WIDTH-1:0]    r_d_rdata;

  assign w_starved = (r_starve_cnt == CntW'(STARVE_LIMIT));
  assign w_f_mis   = |f_addr[1:0];
  assign w_d_mis   = |d_addr[1:0];

  // A flushed fetch never wins, leaving the port free for D in the same cycle.
  assign w_f_gnt = f_req & ~f_flush & ~(d_req & w_starved);
  assign w_d_gnt = d_req & ~w_f_gnt;

  assign w_sel_addr = w_d_gnt ? d_addr : f_addr;
  assign rom_addr   = {w_sel_addr[ADDRESS_WIDTH-1:2], 2'b00};

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_d_gnt || !d_req) begin
      w_starve_nxt = '0;
    end else if (w_f_gnt && !w_starved) begin
      w_starve_nxt = r_starve_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_f_valid    <= 1'b0;
      r_d_valid    <= 1'b0;
      r_f_err      <= 1'b0;
      r_d_err      <= 1'b0;
      r_f_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_f_valid    <= w_f_gnt;
      r_d_valid    <= w_d_gnt;
      r_f_err      <= w_f_gnt & w_f_mis;
      r_d_err      <= w_d_gnt & w_d_mis;
      if (w_f_gnt) begin
        r_f_rdata <= w_f_mis ? '0 : rom_dout;
      end
      if (w_d_gnt) begin
        r_d_rdata <= w_d_mis ? '0 : rom_dout;
      end
    end
  end

  // A flush discards the fetch response arriving in the same cycle.
  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign f_rvalid = r_f_valid & ~f_flush;
  assign f_err    = r_f_err & ~f_flush;
  assign f_rdata  = r_f_rdata;
  assign d_rvalid = r_d_valid;
  assign d_err    = r_d_err;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: stimulus pushes expected grants/responses,
// a monitor pops and compares them every cycle.
module tb_rom_port_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0] f_rdata, d_rdata, rom_addr, rom_dout;

  logic [31:0] mem [64];

  rom_port_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (Limit)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_flush (f_flush),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .f_err   (f_err),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .rom_addr(rom_addr),
    .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;
  always_comb rom_dout = mem[rom_addr[7:2]];

  typedef struct {
    int          cyc;
    bit          is_f;
    bit          drop;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  typedef struct {
    bit          fg;
    bit          dg;
    bit          rst;
    logic [31:0] addr;
  } gnt_t;

  rsp_t rq[$];
  gnt_t gq[$];
  int   cyc = 0;
  int   starve = 0;
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // Reference model: grant rule, starvation count and 1-cycle response, from first principles.
  task automatic step(input bit fr, input logic [31:0] fa, input bit fl, input bit dr,
                      input logic [31:0] da, input bit rs, output bit fg, output bit dg);
    gnt_t g;
    rsp_t r;
    @(negedge clk);
    cyc++;
    rst_n = !rs; f_req = fr; f_addr = fa; f_flush = fl; d_req = dr; d_addr = da;
    if (fl) begin
      foreach (rq[i]) if (rq[i].cyc == cyc && rq[i].is_f) rq[i].drop = 1'b1;
    end
    fg = fr && !fl && !(dr && starve == Limit);
    dg = dr && !fg;
    if (rs) begin
      rq.delete();
      starve = 0;
    end else begin
      if (fg || dg) begin
        r.cyc  = cyc + 1;
        r.is_f = fg;
        r.drop = 1'b0;
        r.err  = fg ? (fa[1:0] != 0) : (da[1:0] != 0);
        r.data = r.err ? 32'h0 : mem[(fg ? fa : da) >> 2];
        rq.push_back(r);
      end
      if (dg || !dr) starve = 0;
      else if (fg && starve < Limit) starve++;
    end
    g.fg   = fg;
    g.dg   = dg;
    g.rst  = rs;
    g.addr = (dg ? da : fa) & 32'hFFFF_FFFC;
    gq.push_back(g);
  endtask

  task automatic idle(input int n);
    bit fg, dg;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, fg, dg);
  endtask

  initial begin : monitor
    gnt_t g;
    rsp_t r;
    bit efv, edv, efe, ede;
    logic [31:0] efd, edd;
    forever begin
      @(negedge clk);
      #4;
      if (gq.size() != 0) begin
        g = gq.pop_front();
        efv = 0; edv = 0; efe = 0; ede = 0; efd = '0; edd = '0;
        while (rq.size() != 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          if (r.cyc < cyc) begin
            nerr++;
            $display("FAIL stale_rsp cycle %0d: got entry for cycle %0d expected none", cyc, r.cyc);
          end else if (!r.drop) begin
            if (r.is_f) begin efv = 1; efe = r.err; efd = r.data; end
            else begin edv = 1; ede = r.err; edd = r.data; end
          end
        end
        chk("f_gnt", 32'(f_gnt), 32'(g.fg));
        chk("d_gnt", 32'(d_gnt), 32'(g.dg));
        chk("rom_addr", rom_addr, g.addr);
        chk("f_rvalid", 32'(f_rvalid), 32'(efv));
        chk("d_rvalid", 32'(d_rvalid), 32'(edv));
        chk("f_err", 32'(f_err), 32'(efe));
        chk("d_err", 32'(d_err), 32'(ede));
        if (efv) chk("f_rdata", f_rdata, efd);
        if (edv) chk("d_rdata", d_rdata, edd);
        if (g.rst) begin
          chk("rst_f_rdata", f_rdata, 32'h0);
          chk("rst_d_rdata", d_rdata, 32'h0);
        end
      end
    end
  end

  initial begin : stim
    bit fg, dg, fh, dh, fr, dr, fl, rs;
    logic [31:0] fa, da;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    step(0, 0, 0, 0, 0, 1, fg, dg);
    step(0, 0, 0, 0, 0, 1, fg, dg);
    idle(1);

    // Fetch stream, single load, both contending under starvation control.
    step(1, 32'h0, 0, 0, 0, 0, fg, dg);
    step(1, 32'h4, 0, 0, 0, 0, fg, dg);
    step(1, 32'h8, 0, 0, 0, 0, fg, dg);
    idle(1);
    step(0, 0, 0, 1, 32'h10, 0, fg, dg);
    idle(1);
    fa = 32'h20;
    da = 32'h80;
    for (int i = 0; i < 12; i++) begin
      step(1, fa, 0, 1, da, 0, fg, dg);
      if (fg) fa += 4;
      if (dg) da += 4;
    end
    idle(1);

    // Misaligned load, flush against a pending fetch response, reset mid-transfer.
    step(0, 0, 0, 1, 32'h13, 0, fg, dg);
    idle(1);
    step(1, 32'h40, 0, 0, 0, 0, fg, dg);
    step(0, 0, 1, 1, 32'h44, 0, fg, dg);
    idle(1);
    step(1, 32'h48, 0, 1, 32'h4C, 0, fg, dg);
    step(0, 0, 0, 0, 0, 1, fg, dg);
    step(0, 0, 0, 1, 32'h50, 0, fg, dg);
    idle(1);

    fh = 0; dh = 0; fa = '0; da = '0; fr = 0; dr = 0;
    for (int i = 0; i < 500; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      if (!fh) begin fr = ($urandom_range(0, 3) != 0); fa = rnd_addr(); end
      if (!dh) begin dr = $urandom_range(0, 1) != 0; da = rnd_addr(); end
      fl = ($urandom_range(0, 7) == 0);
      if (rs) begin fr = 0; dr = 0; end
      step(fr, fa, fl, dr, da, rs, fg, dg);
      fh = fr && !fg && !rs;
      dh = dr && !dg && !rs;
    end
    idle(2);
    @(negedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
